decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage between the fetch stage (PC plus instruction) and the 16×8-bit register file. It accepts one 32-bit instruction per handshake and splits it into fields. It handles register writes for load-immediate (LI) itself and drops NOPs. For every other opcode it reads the source register and presents a decoded operation downstream over a valid/ready handshake.

## Interface
- `PC_W`, 32: width of the PC carried with each instruction.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0); deassertion is synchronous to `clk` upstream.
- `flush`  in  1  synchronous pipeline flush, active-high.
- `in_valid`  in  1  fetch has an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_pc`  in  PC_W  PC of the instruction.
- `in_instr`  in  32  instruction word.
- `rf_rd_addr`  out  4  register file read address; combinational, equals `in_instr[23:20]`.
- `rf_rd_data`  in  8  register file read data; valid one cycle after the address is sampled.
- `rf_wr_enable`  out  1  registered register-file write strobe.
- `rf_wr_addr`  out  4  registered write address.
- `rf_wr_data`  out  8  registered write data.
- `out_valid`  out  1  decoded operation valid.
- `out_ready`  in  1  downstream accepts.
- `out_op`  out  4  opcode.
- `out_rd`  out  4  destination register.
- `out_operand`  out  8  value of the source register.
- `out_imm`  out  8  immediate.
- `out_pc`  out  PC_W  PC of the operation.

## Operation
- Instruction fields:
  - opcode = `[31:28]`
  - rd = `[27:24]`
  - rs = `[23:20]`
  - imm = `[7:0]`
  - bits `[19:8]` are ignored.
- Opcodes:
  - 0x0 NOP: consumed, no output, no write.
  - 0x1 LI: rd ← imm via the register-file write port, no downstream output.
  - 0x2–0xF: operations passed downstream.
- FSM states are IDLE, READ and HOLD.
- IDLE:
  - `in_ready` = ~flush.
  - An accept (in_valid & in_ready) of NOP or LI stays in IDLE. LI sets `rf_wr_enable`=1, `rf_wr_addr`=rd, `rf_wr_data`=imm for exactly the next cycle.
  - An accept of any other opcode latches op, rd, imm and pc, then moves to READ.
- READ:
  - `in_ready`=0.
  - Captures `out_operand` (forwarded or `rf_rd_data`), sets `out_valid`=1, moves to HOLD.
- HOLD:
  - `in_ready`=0.
  - `out_*` are stable while `out_valid` & ~`out_ready`.
  - On out_valid & out_ready: `out_valid`←0 and the state returns to IDLE.
- Forwarding:
  - A non-LI accepted in the cycle where `rf_wr_enable`=1 and `rf_wr_addr`==rs uses `rf_wr_data` as the operand, because the register file returns the old value on a same-edge read/write.
  - The forward decision and value are latched at accept.
- `rf_wr_enable` deasserts after one cycle unless another LI is accepted. Back-to-back LIs are written every cycle.
- Flush:
  - Moves the FSM to IDLE and clears `out_valid` at the next edge. Any latched operation is discarded.
  - An LI write already driven on `rf_wr_*` in the flush cycle still completes.
  - No new write is issued from a flush cycle.
- Flush has priority over `out_ready`. An operation whose out handshake coincides with flush counts as delivered downstream; the stage still goes to IDLE.
- Reset (any time, including mid-READ or mid-HOLD):
  - State returns to IDLE.
  - All registered outputs are 0: `out_valid`, `out_op`, `out_rd`, `out_operand`, `out_imm`, `out_pc`, `rf_wr_enable`, `rf_wr_addr`, `rf_wr_data`.
  - `in_ready` is 0 while reset is asserted.

## Timing
- LI accepted at edge T: `rf_wr_*` are valid from T to T+1, and the register file is written at T+1.
- Non-LI accepted at edge T: the register file samples `rf_rd_addr` at T. `out_valid`=1 from T+1 (after READ completes); the earliest downstream handshake is at edge T+2.
- Earliest next accept after a non-LI is the edge following the out handshake. Throughput is one non-LI operation per 3 cycles and one NOP or LI per cycle.
- `in_ready` depends only on state and `flush`, never on `in_valid`.
- `out_*` depend only on registers; there is no combinational path from `out_ready`.

## Structure
- Shared package `misc_v_pkg`:
  - opcode enum (`OP_NOP`, `OP_LI`, ...)
  - field bit-position constants (`OPC_MSB`, `RD_LSB`, `RS_LSB`, `IMM_W`)
  - register address width (4) and data width (8)
  - `decode_state_t` (IDLE, READ, HOLD)
- No sub-module: field extraction is a package function and the FSM lives in `decode_stage`.

## Test plan
- Reset:
  - Stimulus: drive reset=0 with random inputs, then release.
  - Required: all outputs are 0 during reset; `in_ready`=1 on the first cycle after release.
- LI:
  - Stimulus: LI r3,0x5A (`in_instr`=0x1300_005A) accepted at T.
  - Required: `rf_wr_enable`=1, addr=3, data=0x5A for one cycle only; no `out_valid`.
- Forwarding:
  - Stimulus: LI r3,0x5A then opcode 0x2 with rs=3, rd=7, imm=0x11 on consecutive cycles, register file holding 0x00.
  - Required: `out_operand`=0x5A, `out_rd`=7, `out_imm`=0x11, `out_valid` rising 1 cycle after the second accept.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles during HOLD.
  - Required: `out_*` are stable, `in_ready`=0, and one handshake occurs when `out_ready`=1.
- NOP:
  - Stimulus: a stream of 3 NOPs.
  - Required: each accepted in one cycle; no `out_valid` and no `rf_wr_enable`.
- Flush and reset mid-operation:
  - Stimulus: flush in READ.
  - Required: `out_valid` stays 0 and the stage is back in IDLE with `in_ready`=1 after one cycle.
  - Stimulus: reset asserted in HOLD.
  - Required: `out_valid` drops to 0 immediately (asynchronously).

Source files
------------

// File: rtl/misc_v_pkg.sv
// Shared decode definitions: opcodes, instruction field positions, FSM state
// constants and the field-split helper.
package misc_v_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_DATA_W = 8;
  localparam int unsigned OPC_W      = 4;
  localparam int unsigned OPC_MSB    = 31;
  localparam int unsigned RD_LSB     = 24;
  localparam int unsigned RS_LSB     = 20;
  localparam int unsigned IMM_W      = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LI  = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_MOV = 4'h7
  } opcode_e;

  typedef logic [1:0] decode_state_t;
  localparam decode_state_t IDLE = 2'd0;
  localparam decode_state_t READ = 2'd1;
  localparam decode_state_t HOLD = 2'd2;

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [IMM_W-1:0]      imm;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [31:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPC_MSB -: OPC_W];
    f.rd     = instr[RD_LSB +: REG_ADDR_W];
    f.rs     = instr[RS_LSB +: REG_ADDR_W];
    f.imm    = instr[IMM_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/decode_stage.sv
// Decode stage: splits fetched instructions, performs LI register writes itself,
// drops NOPs and hands other operations downstream with their source operand.
module decode_stage
  import misc_v_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [31:0]           in_instr,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [REG_DATA_W-1:0] rf_rd_data,
  output logic                  rf_wr_enable,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [REG_DATA_W-1:0] rf_wr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPC_W-1:0]      out_op,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [REG_DATA_W-1:0] out_operand,
  output logic [IMM_W-1:0]      out_imm,
  output logic [PC_W-1:0]       out_pc
);

  decode_state_t         state_q, state_d;
  logic                  valid_q, valid_d;
  logic [OPC_W-1:0]      op_q, op_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [REG_DATA_W-1:0] operand_q, operand_d;
  logic [IMM_W-1:0]      imm_q, imm_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [REG_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                  fwd_q, fwd_d;
  logic [REG_DATA_W-1:0] fwd_data_q, fwd_data_d;

  instr_fields_t fields;
  logic          accept;

  assign fields     = split_instr(in_instr);
  assign rf_rd_addr = fields.rs;
  assign in_ready   = reset & ~flush & (state_q == IDLE);
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    op_d       = op_q;
    rd_d       = rd_q;
    operand_d  = operand_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && fields.opcode == OP_LI) begin
            wr_en_d   = 1'b1;
            wr_addr_d = fields.rd;
            wr_data_d = fields.imm;
          end else if (accept && fields.opcode != OP_NOP) begin
            op_d       = fields.opcode;
            rd_d       = fields.rd;
            imm_d      = fields.imm;
            pc_d       = in_pc;
            // The register file returns the old value when written on the read edge.
            fwd_d      = wr_en_q && (wr_addr_q == fields.rs);
            fwd_data_d = wr_data_q;
            state_d    = READ;
          end
        end
        READ: begin
          operand_d = fwd_q ? fwd_data_q : rf_rd_data;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      op_q       <= '0;
      rd_q       <= '0;
      operand_q  <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      operand_q  <= operand_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_op       = op_q;
  assign out_rd       = rd_q;
  assign out_operand  = operand_q;
  assign out_imm      = imm_q;
  assign out_pc       = pc_q;
  assign rf_wr_enable = wr_en_q;
  assign rf_wr_addr   = wr_addr_q;
  assign rf_wr_data   = wr_data_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, random traffic against a
// transaction-level model, and asynchronous reset corner cases.
module tb_decode_stage;

  localparam int NRAND = 1500;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [3:0]  rf_rd_addr;
  logic [7:0]  rf_rd_data;
  logic        rf_wr_enable;
  logic [3:0]  rf_wr_addr;
  logic [7:0]  rf_wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [3:0]  out_rd;
  logic [7:0]  out_operand;
  logic [7:0]  out_imm;
  logic [31:0] out_pc;

  decode_stage #(.PC_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_enable (rf_wr_enable),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_rd       (out_rd),
    .out_operand  (out_operand),
    .out_imm      (out_imm),
    .out_pc       (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read returning the old value on a same-edge write.
  logic [7:0] rf_mem [16];
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) rf_mem[k] <= 8'h00;
      rf_rd_data <= 8'h00;
    end else begin
      if (rf_wr_enable) rf_mem[rf_wr_addr] <= rf_wr_data;
      rf_rd_data <= rf_mem[rf_rd_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [7:0]  e_wd;
    logic [3:0]  e_op;
    logic [3:0]  e_rd;
    logic [7:0]  e_opnd;
    logic [7:0]  e_imm;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                     input logic fl, input logic ordy, input logic ir, input logic ov,
                     input logic we, input logic [3:0] wa, input logic [7:0] wd,
                     input logic [3:0] op, input logic [3:0] rd, input logic [7:0] opnd,
                     input logic [7:0] imm, input logic [31:0] epc);
    vec_t r;
    r = '{v, instr, pc, fl, ordy, ir, ov, we, wa, wd, op, rd, opnd, imm, epc};
    vq.push_back(r);
  endtask

  // Model state for the random phase.
  logic [7:0]  mreg [16];
  bit          pend, li_prev, li_next, acc, exp_ov;
  int          age;
  logic [3:0]  li_wa, e_op, e_rd, m_op, m_rd, m_rs, last_rd;
  logic [7:0]  li_wd, e_opnd, e_imm, m_imm;
  logic [31:0] e_pc;

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;

    // Reset with random inputs: every output must read zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1)); in_instr = $urandom; in_pc = $urandom;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_rf_wr", {19'd0, rf_wr_enable, rf_wr_addr, rf_wr_data}, 32'd0);
      chk("rst_out_fields", {12'd0, out_op, out_rd, out_operand, out_imm}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table: one row per cycle; registered expectations reflect prior edges.
    //   v  instr         pc       fl ordy ir ov we wa  wd     op  rd  opnd   imm    epc
    add(1, 32'h1300_005A, 32'h0,   0, 1,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(1, 32'h2730_0011, 32'h100, 0, 1,   1, 0, 1, 3, 8'h5A, 0, 0, 8'h00, 8'h00, 0);
    add(1, 32'h0000_0000, 32'h0,   0, 0,   0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++)
      add(0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 8'h00, 2, 7, 8'h5A, 8'h11, 32'h100);
    add(0, 32'h0,         32'h0,   0, 1,   0, 1, 0, 0, 8'h00, 2, 7, 8'h5A, 8'h11, 32'h100);
    for (int i = 0; i < 3; i++)
      add(1, 32'h0, 32'h0, 0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(1, 32'h3130_0022, 32'h200, 0, 1,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(0, 32'h0,         32'h0,   1, 1,   0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(0, 32'h0,         32'h0,   0, 1,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(0, 32'h0,         32'h0,   0, 1,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(1, 32'h4230_0033, 32'h300, 0, 1,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(0, 32'h0,         32'h0,   0, 1,   0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(0, 32'h0,         32'h0,   1, 1,   0, 1, 0, 0, 8'h00, 4, 2, 8'h5A, 8'h33, 32'h300);
    add(0, 32'h0,         32'h0,   0, 1,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(1, 32'h1500_0077, 32'h0,   0, 1,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    add(1, 32'h1600_0088, 32'h0,   0, 1,   1, 0, 1, 5, 8'h77, 0, 0, 8'h00, 8'h00, 0);
    add(1, 32'h1900_0099, 32'h0,   1, 1,   0, 0, 1, 6, 8'h88, 0, 0, 8'h00, 8'h00, 0);
    add(0, 32'h0,         32'h0,   0, 1,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      in_valid = vq[i].v; in_instr = vq[i].instr; in_pc = vq[i].pc;
      flush = vq[i].fl; out_ready = vq[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      chk($sformatf("vec%0d_rf_wr_enable", i), 32'(rf_wr_enable), 32'(vq[i].e_we));
      if (vq[i].e_we)
        chk($sformatf("vec%0d_rf_wr", i), {20'd0, rf_wr_addr, rf_wr_data},
            {20'd0, vq[i].e_wa, vq[i].e_wd});
      if (vq[i].e_ov) begin
        chk($sformatf("vec%0d_out_fields", i), {12'd0, out_op, out_rd, out_operand, out_imm},
            {12'd0, vq[i].e_op, vq[i].e_rd, vq[i].e_opnd, vq[i].e_imm});
        chk($sformatf("vec%0d_out_pc", i), out_pc, vq[i].e_pc);
      end
    end

    // Random traffic against an architectural model: each op sees the value of its
    // source register as left by all earlier accepted LIs.
    for (int k = 0; k < 16; k++) mreg[k] = 8'h00;
    mreg[3] = 8'h5A; mreg[5] = 8'h77; mreg[6] = 8'h88;
    pend = 0; li_prev = 0; age = 0; last_rd = 4'd0;
    for (int i = 0; i < NRAND; i++) begin
      @(negedge clk);
      m_op = ($urandom_range(0, 9) < 2) ? 4'h0 :
             ($urandom_range(0, 9) < 5) ? 4'h1 : 4'($urandom_range(2, 15));
      m_rd = 4'($urandom_range(0, 15));
      m_rs = ($urandom_range(0, 2) == 0) ? last_rd : 4'($urandom_range(0, 15));
      m_imm = 8'($urandom);
      in_valid = (i < NRAND - 6) && ($urandom_range(0, 9) < 7);
      in_instr = {m_op, m_rd, m_rs, 12'($urandom), m_imm};
      in_pc = $urandom;
      flush = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      exp_ov = pend && (age >= 1);
      chk("rnd_in_ready", 32'(in_ready), 32'(!pend && !flush));
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("rnd_out_fields", {12'd0, out_op, out_rd, out_operand, out_imm},
            {12'd0, e_op, e_rd, e_opnd, e_imm});
        chk("rnd_out_pc", out_pc, e_pc);
      end
      chk("rnd_rf_wr_enable", 32'(rf_wr_enable), 32'(li_prev));
      if (li_prev)
        chk("rnd_rf_wr", {20'd0, rf_wr_addr, rf_wr_data}, {20'd0, li_wa, li_wd});
      acc = in_valid && !pend && !flush;
      li_next = 0;
      if (flush) pend = 0;
      else if (pend) begin
        if (exp_ov && out_ready) pend = 0;
        else age++;
      end else if (acc && m_op == 4'h1) begin
        mreg[m_rd] = m_imm; li_next = 1; li_wa = m_rd; li_wd = m_imm; last_rd = m_rd;
      end else if (acc && m_op != 4'h0) begin
        pend = 1; age = 0;
        e_op = m_op; e_rd = m_rd; e_opnd = mreg[m_rs]; e_imm = m_imm; e_pc = in_pc;
      end
      li_prev = li_next;
    end

    @(negedge clk);
    for (int k = 0; k < 16; k++)
      chk($sformatf("regfile_r%0d", k), 32'(rf_mem[k]), 32'(mreg[k]));

    // Drain, then assert reset while an operation sits in HOLD.
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h2000_0000; in_pc = 32'hABCD; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_out_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_out_pc", out_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("rst_release_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
